pim_vec_sequencer: RTL and testbench

//  Upstream controller for the PIM FP execution unit (ADD 5'b10000 / MUL 5'b10010).

---
 rtl/pim_vec_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_pim_vec_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pim_vec_sequencer.sv
// ---------------------------------------------------------------------------
// pim_vec_sequencer
//
// Upstream controller for the PIM floating-point execution unit. Accepts one
// vector job (op, A base, B base, DST base, length) and, per element, reads
// A[i] and B[i] from the local page SRAM, launches one ALU operation, waits
// for the result and writes it to DST[i]. Only ADD (5'b10000) and MUL
// (5'b10010) are accepted. Any other op ends the job with err = 1.
//
// Handshake: a job is accepted on a rising clk edge where req_valid and
// req_ready are both 1. req_ready is 1 exactly when the sequencer is idle.
// The req_* fields are sampled only in that accepting cycle.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     job request handshake
//   req_op              ALU command used for every element of the job
//   req_src_a/b, dst    vector base word addresses (wrap modulo 2^ADDR_W)
//   req_len             element count (0 allowed)
//   mem_rd_*            SRAM read port (data returns one cycle after rd_en)
//   mem_wr_*            SRAM write port
//   alu_cmd/data1/data2 command and operands to the execution unit
//   alu_result(_valid)  result from the execution unit (1-cycle valid pulse)
//   busy                a job is in progress
//   done, err           1-cycle job-end pulse; err qualifies done
//   dbg_state           current FSM state, for observation only
// ---------------------------------------------------------------------------
module pim_vec_sequencer #(
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [ADDR_W-1:0] req_src_a,
    input  logic [ADDR_W-1:0] req_src_b,
    input  logic [ADDR_W-1:0] req_dst,
    input  logic [LEN_W-1:0]  req_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [4:0]        alu_cmd,
    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_result_valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    localparam logic [4:0] OP_ADD = 5'b10000;
    localparam logic [4:0] OP_MUL = 5'b10010;
    localparam int         CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_LOAD = 3'd3,
        S_EXEC = 3'd4,
        S_WB   = 3'd5,
        S_FIN  = 3'd6
    } state_t;

    state_t            state, state_d;
    logic              err_q, err_d;
    logic [4:0]        op_q;
    logic [ADDR_W-1:0] src_a_q, src_b_q, dst_q;
    logic [LEN_W-1:0]  len_q, idx_q;
    logic [CNT_W-1:0]  tmo_q;
    logic              op_ok;
    logic              last_elem;
    logic              tmo_hit;

    assign op_ok     = (req_op == OP_ADD) || (req_op == OP_MUL);
    assign last_elem = ((idx_q + LEN_W'(1)) == len_q);
    assign tmo_hit   = (tmo_q == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_d     = state;
        err_d       = err_q;
        req_ready   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = src_a_q + ADDR_W'(idx_q);
        alu_cmd     = 5'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!op_ok) begin
                        state_d = S_FIN;
                        err_d   = 1'b1;
                    end else if (req_len == '0) begin
                        state_d = S_FIN;
                        err_d   = 1'b0;
                    end else begin
                        state_d = S_RD_A;
                        err_d   = 1'b0;
                    end
                end
            end
            S_RD_A: begin
                mem_rd_en = 1'b1;
                state_d   = S_RD_B;
            end
            S_RD_B: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = src_b_q + ADDR_W'(idx_q);
                state_d     = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // The exec unit starts on the 0 -> non-zero edge of alu_cmd;
                // the command is held for the whole wait.
                alu_cmd = op_q;
                if (alu_result_valid) begin
                    state_d = S_WB;
                end else if (tmo_hit) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                end
            end
            S_WB: begin
                // alu_cmd is 0 here, giving the zero gap before the next launch.
                state_d = last_elem ? S_FIN : S_RD_A;
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign err       = done & err_q;
    assign dbg_state = state;

    // Job registers and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q       <= 1'b0;
            op_q        <= '0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            alu_data1   <= '0;
            alu_data2   <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            err_q     <= err_d;
            mem_wr_en <= 1'b0;
            tmo_q     <= (state == S_EXEC) ? tmo_q + CNT_W'(1) : '0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        src_a_q <= req_src_a;
                        src_b_q <= req_src_b;
                        dst_q   <= req_dst;
                        len_q   <= req_len;
                        idx_q   <= '0;
                    end
                end
                S_RD_B: alu_data1 <= mem_rd_data;
                S_LOAD: alu_data2 <= mem_rd_data;
                S_EXEC: begin
                    // Write is issued during WB, so it never overlaps a read.
                    if (alu_result_valid) begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= dst_q + ADDR_W'(idx_q);
                        mem_wr_data <= alu_result;
                    end
                end
                S_WB: idx_q <= idx_q + LEN_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pim_vec_sequencer.sv
module tb_pim_vec_sequencer;

  localparam int ADDR_W  = 10;
  localparam int LEN_W   = 10;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam logic [4:0] OP_ADD = 5'b10000;
  localparam logic [4:0] OP_MUL = 5'b10010;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [4:0]        req_op = '0;
  logic [ADDR_W-1:0] req_src_a = '0, req_src_b = '0, req_dst = '0;
  logic [LEN_W-1:0]  req_len = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [4:0]        alu_cmd;
  logic [DATA_W-1:0] alu_data1, alu_data2;
  logic [DATA_W-1:0] alu_result;
  logic              alu_result_valid;
  logic              busy, done, err;
  logic [2:0]        dbg_state;

  pim_vec_sequencer #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src_a(req_src_a), .req_src_b(req_src_b), .req_dst(req_dst), .req_len(req_len),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .alu_cmd(alu_cmd), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_result(alu_result), .alu_result_valid(alu_result_valid),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- SRAM model (1-cycle read latency) ----------------
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              pre_en = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  // ---------------- exec unit model ----------------
  // Hand-computed results for the operand pairs used in the directed tests.
  function automatic logic [31:0] fp_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [68:0] key;
    key = {op, a, b};
    case (key)
      {OP_ADD, 32'h3F800000, 32'h3F000000}: return 32'h3FC00000;
      {OP_ADD, 32'h40000000, 32'h3F000000}: return 32'h40200000;
      {OP_ADD, 32'h40400000, 32'h3F000000}: return 32'h40600000;
      {OP_MUL, 32'h40000000, 32'h40400000}: return 32'h40C00000;
      default: return 32'hFFFFFFFF;
    endcase
  endfunction

  int   exec_lat = 3;
  logic mute = 1'b0;
  logic stray = 1'b0;
  logic [4:0] model_prev_cmd = '0;
  int   pend = 0;
  logic res_pulse = 1'b0;
  logic [DATA_W-1:0] res_q = '0;

  always @(posedge clk) begin
    res_pulse <= 1'b0;
    if (alu_cmd != 5'b0 && model_prev_cmd == 5'b0 && !mute) begin
      pend <= exec_lat;
    end else if (pend != 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        res_pulse <= 1'b1;
        res_q     <= fp_model(alu_cmd, alu_data1, alu_data2);
      end
    end
    model_prev_cmd <= alu_cmd;
  end

  assign alu_result_valid = res_pulse | stray;
  assign alu_result       = res_q;

  // ---------------- scoreboard ----------------
  logic [ADDR_W+DATA_W-1:0] exp_q[$];      // expected {wr_addr, wr_data}
  logic [16:0]              exp_done_q[$]; // expected {err, max cycles after accept}
  int checks = 0;
  int errors = 0;
  int rd_cnt = 0, wr_cnt = 0, cmd_cycles = 0;
  int accept_cyc = 0;
  logic first_launch = 1'b0;
  logic [4:0] exp_op = '0;
  logic [4:0] mon_prev_cmd = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en && mem_wr_en) check("rd_wr_overlap", 1, 0);
      if (mem_rd_en) rd_cnt++;
      if (alu_cmd != 5'b0) cmd_cycles++;
      if (mem_wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", {mem_wr_addr, mem_wr_data}, 0);
        end else begin
          logic [ADDR_W+DATA_W-1:0] e;
          e = exp_q.pop_front();
          check("write", {mem_wr_addr, mem_wr_data}, e);
        end
      end
      if (alu_cmd != 5'b0 && mon_prev_cmd == 5'b0) begin
        check("launch_op", alu_cmd, exp_op);
        if (first_launch) begin
          check("launch_latency", cyc - accept_cyc, 3);
          first_launch = 1'b0;
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          logic [16:0] d;
          d = exp_done_q.pop_front();
          check("done_err", err, d[16]);
          check("done_within_bound", (cyc - accept_cyc) <= int'(d[15:0]), 1);
        end
      end
    end
    mon_prev_cmd = alu_cmd;
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic issue(input logic [4:0] op, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                       input logic [ADDR_W-1:0] d, input logic [LEN_W-1:0] len);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 0, 1);
    exp_op = op;
    first_launch = 1'b1;
    req_op = op; req_src_a = a; req_src_b = b; req_dst = d; req_len = len;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("done_seen", seen, 1);
  endtask

  task automatic run_job(input logic [4:0] op, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                         input logic [ADDR_W-1:0] d, input logic [LEN_W-1:0] len,
                         input logic exp_err, input int max_lat);
    exp_done_q.push_back({exp_err, 16'(max_lat)});
    issue(op, a, b, d, len);
    wait_done();
  endtask

  // ---------------- stimulus ----------------
  int rd0, wr0, cmd0;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_req_ready", req_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_alu_cmd", alu_cmd, 0);
    check("reset_rd_en", mem_rd_en, 0);
    check("reset_wr_en", mem_wr_en, 0);
    check("reset_state", dbg_state, 0);
    rst_n = 1'b1;

    // Operands
    preload(10'd0,   32'h3F800000);
    preload(10'd1,   32'h40000000);
    preload(10'd2,   32'h40400000);
    preload(10'd100, 32'h3F000000);
    preload(10'd101, 32'h3F000000);
    preload(10'd102, 32'h3F000000);
    preload(10'd300, 32'h40000000);
    preload(10'd301, 32'h40400000);
    preload(10'd1023, 32'h3F800000);

    // 1. ADD, len 3
    rd0 = rd_cnt; wr0 = wr_cnt;
    exp_q.push_back({10'd200, 32'h3FC00000});
    exp_q.push_back({10'd201, 32'h40200000});
    exp_q.push_back({10'd202, 32'h40600000});
    run_job(OP_ADD, 10'd0, 10'd100, 10'd200, 10'd3, 1'b0, 1000);
    check("t1_writes", wr_cnt - wr0, 3);
    check("t1_reads", rd_cnt - rd0, 6);

    // 2. MUL, len 1, single-cycle exec latency
    exec_lat = 1;
    exp_q.push_back({10'd400, 32'h40C00000});
    run_job(OP_MUL, 10'd300, 10'd301, 10'd400, 10'd1, 1'b0, 1000);
    exec_lat = 3;

    // 3. illegal op
    rd0 = rd_cnt; wr0 = wr_cnt; cmd0 = cmd_cycles;
    run_job(5'b00011, 10'd0, 10'd100, 10'd500, 10'd4, 1'b1, 2);
    check("t3_no_reads", rd_cnt - rd0, 0);
    check("t3_no_writes", wr_cnt - wr0, 0);
    check("t3_no_alu", cmd_cycles - cmd0, 0);

    // 4. len 0
    rd0 = rd_cnt; wr0 = wr_cnt; cmd0 = cmd_cycles;
    run_job(OP_ADD, 10'd0, 10'd100, 10'd500, 10'd0, 1'b0, 2);
    check("t4_no_reads", rd_cnt - rd0, 0);
    check("t4_no_writes", wr_cnt - wr0, 0);
    check("t4_no_alu", cmd_cycles - cmd0, 0);

    // 5. timeout: exec never answers
    mute = 1'b1;
    wr0 = wr_cnt; cmd0 = cmd_cycles;
    run_job(OP_ADD, 10'd0, 10'd100, 10'd600, 10'd2, 1'b1, 1000);
    check("t5_exec_cycles", cmd_cycles - cmd0, TIMEOUT);
    check("t5_cmd_zero_at_done", alu_cmd, 0);
    check("t5_no_writes", wr_cnt - wr0, 0);
    mute = 1'b0;
    @(negedge clk);
    check("t5_idle_after", req_ready, 1);

    // Stray result_valid while idle must be ignored
    wr0 = wr_cnt;
    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    @(negedge clk);
    check("stray_no_write", wr_cnt - wr0, 0);
    check("stray_not_busy", busy, 0);

    // 6. address wrap: A at 1023 then 0, DST at 1023 then 0
    rd0 = rd_cnt;
    exp_q.push_back({10'd1023, 32'h3FC00000});
    exp_q.push_back({10'd0,    32'h40200000});
    preload(10'd0, 32'h40000000);
    run_job(OP_ADD, 10'd1023, 10'd100, 10'd1023, 10'd2, 1'b0, 1000);
    check("t6_reads", rd_cnt - rd0, 4);

    // Reset during EXEC
    mute = 1'b1;
    wr0 = wr_cnt;
    preload(10'd300, 32'h40000000);
    issue(OP_MUL, 10'd300, 10'd301, 10'd700, 10'd1);
    begin
      int n;
      n = 0;
      while (alu_cmd == 5'b0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("rst_reached_exec", alu_cmd, OP_MUL);
    end
    rst_n = 1'b0;
    #1;
    check("rst_alu_cmd", alu_cmd, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mute = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_no_write", wr_cnt - wr0, 0);
    check("rst_mem_untouched", mem[700] === 32'h40C00000, 0);

    repeat (5) @(negedge clk);
    check("exp_writes_drained", exp_q.size(), 0);
    check("exp_done_drained", exp_done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time guard
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

endmodule
